input_buffer_logic: RTL and testbench



---
 rtl/input_buffer_logic.sv | 140 ++++++++++++++
 tb/tb_input_buffer_logic.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_buffer_logic.sv
// Byte-to-packet deserializer feeding a first-word fall-through packet queue.
// Reports overflow drops, inter-byte timeouts and queue free space upstream.
module input_buffer_logic #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  payload_inbound,
  input  logic        put_inbound,
  output logic        free_inbound,
  output logic [31:0] pkt,
  output logic        pkt_avail,
  input  logic        read_pkt,
  output logic        overflow,
  output logic        timeout_err,
  output logic [7:0]  drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [23:0]   held_q, held_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          complete, expire;
  logic [31:0]   complete_pkt;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push, pop, full, drop;

  assign complete_pkt = {held_q, payload_inbound};

  // Byte assembly: a byte arriving on the expiry cycle always wins over the timeout.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    held_d     = held_q;
    timer_d    = timer_q;
    complete   = 1'b0;
    expire     = 1'b0;
    case (state_q)
      IDLE: begin
        if (put_inbound) begin
          held_d     = {payload_inbound, 16'h0000};
          byte_cnt_d = 2'd1;
          timer_d    = '0;
          state_d    = COLLECT;
        end
      end
      COLLECT: begin
        if (put_inbound) begin
          timer_d = '0;
          case (byte_cnt_q)
            2'd1: begin
              held_d[15:8] = payload_inbound;
              byte_cnt_d   = 2'd2;
            end
            2'd2: begin
              held_d[7:0] = payload_inbound;
              byte_cnt_d  = 2'd3;
            end
            default: begin
              complete   = 1'b1;
              byte_cnt_d = 2'd0;
              state_d    = IDLE;
            end
          endcase
        end else if (TIMEOUT > 0) begin
          if (timer_q == TW'(TIMEOUT - 1)) begin
            expire     = 1'b1;
            byte_cnt_d = 2'd0;
            timer_d    = '0;
            state_d    = IDLE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= 2'd0;
      held_q     <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      held_q     <= held_d;
      timer_q    <= timer_d;
    end
  end

  // A full queue still accepts a completed packet when the head leaves in the same cycle.
  assign full = (count_q == CW'(FIFO_DEPTH));
  assign pop  = read_pkt && (count_q != '0);
  assign push = complete && (!full || pop);
  assign drop = complete && full && !pop;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= complete_pkt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
      drop_count  <= 8'h00;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      overflow    <= drop;
      timeout_err <= expire;
      if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end

  assign pkt_avail    = (count_q != '0);
  assign pkt          = pkt_avail ? mem[rd_ptr_q] : 32'h0;
  assign free_inbound = (count_q < CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_input_buffer_logic.sv
// Randomized and directed bench for input_buffer_logic with a byte-queue reference
// model and a scoreboard whose monitor checks every popped packet.
module tb_input_buffer_logic;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  payload_inbound;
  logic        put_inbound;
  logic        free_inbound;
  logic [31:0] pkt;
  logic        pkt_avail;
  logic        read_pkt;
  logic        overflow;
  logic        timeout_err;
  logic [7:0]  drop_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  partial[$];
  int          idle_cnt;
  int          model_occ;
  int          model_drops;
  logic        exp_ovf;
  logic        exp_to;

  input_buffer_logic #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clock(clock),
    .reset(reset),
    .payload_inbound(payload_inbound),
    .put_inbound(put_inbound),
    .free_inbound(free_inbound),
    .pkt(pkt),
    .pkt_avail(pkt_avail),
    .read_pkt(read_pkt),
    .overflow(overflow),
    .timeout_err(timeout_err),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic checkOutput();
    logic [31:0] head;
    head = (model_occ > 0 && exp_q.size() > 0) ? exp_q[0] : 32'h0;
    cmp("pkt_avail", 32'(pkt_avail), 32'(model_occ > 0));
    cmp("free_inbound", 32'(free_inbound), 32'(model_occ < DEPTH));
    cmp("pkt", pkt, head);
    cmp("overflow", 32'(overflow), 32'(exp_ovf));
    cmp("timeout_err", 32'(timeout_err), 32'(exp_to));
    cmp("drop_count", 32'(drop_count), 32'(model_drops));
  endtask

  task automatic modelReset();
    exp_q.delete();
    partial.delete();
    idle_cnt    = 0;
    model_occ   = 0;
    model_drops = 0;
    exp_ovf     = 1'b0;
    exp_to      = 1'b0;
  endtask

  // Reference: bytes gather in a list; four of them make a packet, too long a gap drops them.
  task automatic modelStep(input logic p, input logic [7:0] b, input logic r);
    logic        popping;
    logic [31:0] w;
    popping = r && (model_occ > 0);
    exp_ovf = 1'b0;
    exp_to  = 1'b0;
    if (p) begin
      partial.push_back(b);
      idle_cnt = 0;
      if (partial.size() == 4) begin
        w = {partial[0], partial[1], partial[2], partial[3]};
        partial.delete();
        if (model_occ < DEPTH || popping) begin
          exp_q.push_back(w);
          model_occ++;
        end else begin
          exp_ovf = 1'b1;
          if (model_drops < 255) model_drops++;
        end
      end
    end else if (partial.size() > 0 && TMO > 0) begin
      idle_cnt++;
      if (idle_cnt == TMO) begin
        partial.delete();
        idle_cnt = 0;
        exp_to   = 1'b1;
      end
    end
    if (popping) model_occ--;
  endtask

  task automatic applyStimulus(input logic p, input logic [7:0] b, input logic r);
    @(negedge clock);
    checkOutput();
    put_inbound     = p;
    payload_inbound = b;
    read_pkt        = r;
    modelStep(p, b, r);
  endtask

  task automatic idleCycles(input int n, input logic r);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, r);
  endtask

  task automatic sendPacket(input logic [31:0] w, input logic readLast);
    applyStimulus(1'b1, w[31:24], 1'b0);
    applyStimulus(1'b1, w[23:16], 1'b0);
    applyStimulus(1'b1, w[15:8],  1'b0);
    applyStimulus(1'b1, w[7:0],   readLast);
  endtask

  task automatic doReset();
    @(negedge clock);
    checkOutput();
    put_inbound = 1'b0;
    read_pkt    = 1'b0;
    #1 reset = 1'b1;
    modelReset();
    #1 checkOutput();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Monitor: whenever the DUT hands out its head packet, it must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (!reset && read_pkt && pkt_avail) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL pop data: got %h expected none at %0t", pkt, $time);
        end else begin
          cmp("pop data", pkt, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    put_inbound     = 1'b0;
    payload_inbound = 8'h00;
    read_pkt        = 1'b0;
    reset           = 1'b1;
    modelReset();
    @(negedge clock);
    @(negedge clock);
    checkOutput();
    reset = 1'b0;

    $display("[TB] single packet AABBCCDD");
    sendPacket(32'hAABBCCDD, 1'b0);
    idleCycles(1, 1'b1);
    idleCycles(2, 1'b0);

    $display("[TB] three back-to-back packets");
    for (int i = 1; i <= 12; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    idleCycles(2, 1'b0);
    idleCycles(3, 1'b1);
    idleCycles(1, 1'b0);

    $display("[TB] fill queue and overflow");
    for (int i = 0; i < DEPTH; i++) sendPacket(32'hC0DE0000 | 32'(i), 1'b0);
    sendPacket(32'hDEADBEEF, 1'b0);
    idleCycles(2, 1'b0);
    sendPacket(32'hFEEDF00D, 1'b1);
    idleCycles(1, 1'b0);
    idleCycles(DEPTH, 1'b1);
    idleCycles(1, 1'b0);

    $display("[TB] inter-byte timeout");
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    idleCycles(TMO + 2, 1'b0);
    sendPacket(32'h33445566, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b0);
    applyStimulus(1'b1, 8'h88, 1'b0);
    idleCycles(TMO - 1, 1'b0);
    applyStimulus(1'b1, 8'h99, 1'b0);
    applyStimulus(1'b1, 8'hAA, 1'b0);
    idleCycles(2, 1'b1);
    idleCycles(1, 1'b0);

    $display("[TB] reset mid-packet with queued packets");
    sendPacket(32'h01010101, 1'b0);
    sendPacket(32'h02020202, 1'b0);
    applyStimulus(1'b1, 8'h5A, 1'b0);
    applyStimulus(1'b1, 8'hA5, 1'b0);
    doReset();
    sendPacket(32'h13579BDF, 1'b0);
    idleCycles(1, 1'b1);
    idleCycles(1, 1'b0);

    $display("[TB] drop counter saturation");
    for (int i = 0; i < DEPTH; i++) sendPacket(32'h0F0F0000 | 32'(i), 1'b0);
    for (int i = 0; i < 260; i++) sendPacket(32'(i) * 32'h01010101, 1'b0);
    idleCycles(1, 1'b0);
    idleCycles(DEPTH, 1'b1);
    idleCycles(1, 1'b0);
    doReset();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        idleCycles(int'($urandom_range(10, 20)), 1'($urandom_range(0, 1)));
      end else begin
        applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0));
      end
    end
    idleCycles(TMO + 2, 1'b0);
    idleCycles(DEPTH + 1, 1'b1);
    idleCycles(1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
